// File: rtl/float_mul_arbiter_pkg.sv
// ============================================================================
// Module  : float_mul_arbiter_pkg
// Brief   : Shared float format parameters and a small index-width helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package float_mul_arbiter_pkg;

  localparam int float_width      = 32;
  localparam int float_exp_width  = 8;
  localparam int float_mant_width = 23;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/float_mul_arbiter_rr_picker.sv
// ============================================================================
// Module  : rr_picker
// Brief   : Combinational round-robin pick of the first pending client at or
//           after rr_ptr.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_picker
  import float_mul_arbiter_pkg::*;
#(
  parameter int num_clients = 4
) (
  input  logic [num_clients-1:0]            pending,
  input  logic [idx_width(num_clients)-1:0] rr_ptr,
  output logic [idx_width(num_clients)-1:0] winner,
  output logic                              any_valid
);

  localparam int IDX_W = idx_width(num_clients);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_cand;

  // Scan from the farthest offset down so the closest pending slot wins last.
  always_comb begin
    winner    = rr_ptr;
    any_valid = 1'b0;
    w_sum     = '0;
    w_cand    = '0;
    for (int k = num_clients - 1; k >= 0; k--) begin
      w_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(num_clients)) begin
        w_sum = w_sum - (IDX_W+1)'(num_clients);
      end
      w_cand = w_sum[IDX_W-1:0];
      if (pending[w_cand]) begin
        winner    = w_cand;
        any_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/float_mul_arbiter.sv
// ============================================================================
// Module  : float_mul_arbiter
// Brief   : Round-robin arbiter sharing one float multiplier among clients.
// Revision: 1.0
// ============================================================================
`default_nettype none

module float_mul_arbiter
  import float_mul_arbiter_pkg::*;
#(
  parameter int num_clients = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [num_clients-1:0]             cl_req,
  input  logic [num_clients*float_width-1:0] cl_a,
  input  logic [num_clients*float_width-1:0] cl_b,
  output logic [num_clients-1:0]             cl_ack,
  output logic [float_width-1:0]             cl_out,
  output logic                               mul_req,
  output logic [float_width-1:0]             mul_a,
  output logic [float_width-1:0]             mul_b,
  input  logic                               mul_ack,
  input  logic [float_width-1:0]             mul_out,
  output logic                               busy,
  output logic                               err
);

  localparam int IDX_W = idx_width(num_clients);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [num_clients-1:0] pending_q, pending_d;
  logic [float_width-1:0] op_a_q [num_clients];
  logic [float_width-1:0] op_b_q [num_clients];
  logic [IDX_W-1:0]       winner_q, winner_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [float_width-1:0] result_q, result_d;
  logic [float_width-1:0] mul_a_q, mul_a_d;
  logic [float_width-1:0] mul_b_q, mul_b_d;
  logic                   err_q, err_d;

  logic [num_clients-1:0] w_accept;
  logic [num_clients-1:0] w_drop;
  logic [IDX_W-1:0]       w_pick;
  logic                   w_pick_valid;

  // Acceptance looks at the registered pending bits, so the winner's own
  // request in its DONE cycle is still seen as a duplicate.
  assign w_accept = cl_req & ~pending_q;
  assign w_drop   = cl_req &  pending_q;

  rr_picker #(
    .num_clients (num_clients)
  ) u_rr_picker (
    .pending   (pending_q),
    .rr_ptr    (rr_ptr_q),
    .winner    (w_pick),
    .any_valid (w_pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    winner_d  = winner_q;
    rr_ptr_d  = rr_ptr_q;
    result_d  = result_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    err_d     = err_q;

    if ((|w_drop) || (mul_ack && (state_q != WAIT))) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (w_pick_valid) begin
          winner_d = w_pick;
          mul_a_d  = op_a_q[w_pick];
          mul_b_d  = op_b_q[w_pick];
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mul_ack) begin
          result_d = mul_out;
          state_d  = DONE;
        end
      end
      DONE: begin
        pending_d[winner_q] = 1'b0;
        rr_ptr_d = (winner_q == IDX_W'(num_clients - 1)) ? '0 : winner_q + IDX_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    pending_d = pending_d | w_accept;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      winner_q  <= '0;
      rr_ptr_q  <= '0;
      result_q  <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      winner_q  <= winner_d;
      rr_ptr_q  <= rr_ptr_d;
      result_q  <= result_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < num_clients; i++) begin
        op_a_q[i] <= '0;
        op_b_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < num_clients; i++) begin
        if (w_accept[i]) begin
          op_a_q[i] <= cl_a[i*float_width +: float_width];
          op_b_q[i] <= cl_b[i*float_width +: float_width];
        end
      end
    end
  end

  always_comb begin
    cl_ack = '0;
    cl_out = '0;
    if (state_q == DONE) begin
      cl_ack[winner_q] = 1'b1;
      cl_out           = result_q;
    end
  end

  assign mul_req = (state_q == ISSUE);
  assign mul_a   = mul_a_q;
  assign mul_b   = mul_b_q;
  assign busy    = (state_q != IDLE) || (|pending_q);
  assign err     = err_q;

endmodule

`default_nettype wire
